// File: rtl/maj3_xnor2_pkg.sv
// Shared types and reference/alternative logic-cell functions for the
// majority/XNOR self-test block.
package maj3_xnor2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int unsigned VEC_W = 3;

   function automatic logic maj_gold(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Pass-gate style: when a and b disagree, c breaks the tie
   function automatic logic maj_alt(input logic a, input logic b, input logic c);
      return (a ^ b) ? c : a;
   endfunction

   function automatic logic xnor_gold(input logic a, input logic b);
      return (a & b) | (~a & ~b);
   endfunction

   function automatic logic xnor_alt(input logic a, input logic b);
      return ~(a ^ b);
   endfunction

endpackage

// File: rtl/maj3_xnor2_core.sv
// Combinational gold/alternative majority and XNOR evaluation with a
// cross-check flag; the fault hook only disturbs the alternative majority.
module maj3_xnor2_core
   import maj3_xnor2_pkg::*;
(
   input  logic [VEC_W-1:0] vec_i,
   input  logic             fault_inj_i,
   output logic             maj_c_o,
   output logic             maj_alt_c_o,
   output logic             xnor_c_o,
   output logic             xnor_alt_c_o,
   output logic             mismatch_c_o
);

   logic a, b, c;

   assign a = vec_i[0];
   assign b = vec_i[1];
   assign c = vec_i[2];

   assign maj_c_o      = maj_gold(a, b, c);
   assign maj_alt_c_o  = maj_alt(a, b, c) ^ fault_inj_i;
   assign xnor_c_o     = xnor_gold(a, b);
   assign xnor_alt_c_o = xnor_alt(a, b);
   assign mismatch_c_o = (maj_c_o != maj_alt_c_o) | (xnor_c_o != xnor_alt_c_o);

endmodule

// File: rtl/maj3_xnor2_selftest.sv
// Registered majority/XNOR cells with an exhaustive on-chip sweep engine
// that cross-checks the gold and alternative implementations.
module maj3_xnor2_selftest
   import maj3_xnor2_pkg::*;
#(
   parameter int unsigned SWEEP_LEN = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mode,
   input  logic                         start,
   input  logic                         a_i,
   input  logic                         b_i,
   input  logic                         c_i,
   input  logic                         fault_inj,
   output logic                         maj_o,
   output logic                         maj_alt_o,
   output logic                         xnor_o,
   output logic                         xnor_alt_o,
   output logic                         mismatch,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [$clog2(SWEEP_LEN)-1:0] vec_idx
);

   localparam int unsigned IDX_W = $clog2(SWEEP_LEN);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              err_q, err_d;
   logic              tail_q, tail_d;

   logic              maj_q, maj_alt_q, xnor_q, xnor_alt_q, mismatch_q;
   logic              maj_c, maj_alt_c, xnor_c, xnor_alt_c, mismatch_c;
   logic [VEC_W-1:0]  vec_c;
   logic              use_int_c;

   // An in-flight sweep keeps internal vectors even if mode drops
   assign use_int_c = mode | (state_q == ST_SWEEP);
   assign vec_c     = use_int_c ? idx_q[VEC_W-1:0] : {c_i, b_i, a_i};

   maj3_xnor2_core u_core (
      .vec_i        (vec_c),
      .fault_inj_i  (fault_inj),
      .maj_c_o      (maj_c),
      .maj_alt_c_o  (maj_alt_c),
      .xnor_c_o     (xnor_c),
      .xnor_alt_c_o (xnor_alt_c),
      .mismatch_c_o (mismatch_c)
   );

   // Result registers: one-cycle latency from operand select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maj_q      <= 1'b0;
         maj_alt_q  <= 1'b0;
         xnor_q     <= 1'b0;
         xnor_alt_q <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         maj_q      <= maj_c;
         maj_alt_q  <= maj_alt_c;
         xnor_q     <= xnor_c;
         xnor_alt_q <= xnor_alt_c;
         mismatch_q <= mismatch_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         err_q   <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      tail_d  = tail_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && mode) begin
               state_d = ST_SWEEP;
               idx_d   = '0;
               err_d   = 1'b0;
               tail_d  = 1'b0;
            end
         end
         ST_SWEEP: begin
            // Registered mismatch at idx 0 belongs to the pre-sweep vector
            if (tail_q || (idx_q != '0)) begin
               err_d = err_q | mismatch_q;
            end
            if (tail_q) begin
               state_d = ST_DONE;
               tail_d  = 1'b0;
            end else if (idx_q == IDX_W'(SWEEP_LEN - 1)) begin
               tail_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (!mode) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_SWEEP;
               idx_d   = '0;
               err_d   = 1'b0;
               tail_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign maj_o      = maj_q;
   assign maj_alt_o  = maj_alt_q;
   assign xnor_o     = xnor_q;
   assign xnor_alt_o = xnor_alt_q;
   assign mismatch   = mismatch_q;
   assign busy       = (state_q == ST_SWEEP);
   assign done       = (state_q == ST_DONE);
   assign pass       = (state_q == ST_DONE) & ~err_q;
   assign vec_idx    = idx_q;

endmodule

// File: tb/tb_maj3_xnor2_selftest.sv
// Directed self-checking bench for the majority/XNOR self-test block.
module tb_maj3_xnor2_selftest;

   localparam int unsigned SWEEP_LEN = 16;
   localparam int unsigned IDX_W     = $clog2(SWEEP_LEN);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             mode, start, a_i, b_i, c_i, fault_inj;
   logic             maj_o, maj_alt_o, xnor_o, xnor_alt_o;
   logic             mismatch, busy, done, pass;
   logic [IDX_W-1:0] vec_idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   maj3_xnor2_selftest #(.SWEEP_LEN(SWEEP_LEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .start      (start),
      .a_i        (a_i),
      .b_i        (b_i),
      .c_i        (c_i),
      .fault_inj  (fault_inj),
      .maj_o      (maj_o),
      .maj_alt_o  (maj_alt_o),
      .xnor_o     (xnor_o),
      .xnor_alt_o (xnor_alt_o),
      .mismatch   (mismatch),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .vec_idx    (vec_idx)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [10:0] all_o;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         {mode, start, a_i, b_i, c_i, fault_inj} = 6'($urandom);
         step();
         all_o = {maj_o, maj_alt_o, xnor_o, xnor_alt_o, mismatch, busy, done, pass,
                  3'(vec_idx)};
         n_checks++;
         if ({all_o, vec_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b vec_idx=%0d, want all zero", all_o, vec_idx);
         end
      end
      {mode, start, a_i, b_i, c_i, fault_inj} = '0;
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release: busy/done=%b, want 00", {busy, done});
      end
   endtask

   task automatic test_external();
      logic [2:0] cba [4]  = '{3'b000, 3'b011, 3'b001, 3'b110};
      logic [1:0] expv [4] = '{2'b01, 2'b11, 2'b00, 2'b10}; // {maj, xnor}
      mode = 1'b0;
      fault_inj = 1'b0;
      for (int i = 0; i < 4; i++) begin
         {c_i, b_i, a_i} = cba[i];
         step();
         n_checks++;
         if ({maj_o, xnor_o} !== expv[i]) begin
            n_fail++;
            $display("FAIL ext_gold cba=%b: maj/xnor=%b want %b", cba[i], {maj_o, xnor_o}, expv[i]);
         end
         n_checks++;
         if ({maj_alt_o, xnor_alt_o, mismatch} !== {expv[i], 1'b0}) begin
            n_fail++;
            $display("FAIL ext_alt cba=%b: alt maj/xnor,mismatch=%b want %b",
                     cba[i], {maj_alt_o, xnor_alt_o, mismatch}, {expv[i], 1'b0});
         end
      end
   endtask

   // Starts from IDLE or DONE with mode=1; returns after the first SWEEP edge
   task automatic launch(input logic fi);
      mode = 1'b1;
      fault_inj = fi;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_sweep(input logic fi, input string tag);
      logic [2:0] v;
      logic       em, ex;
      launch(fi);
      for (int k = 0; k <= SWEEP_LEN; k++) begin
         n_checks++;
         if (busy !== 1'b1 || vec_idx !== IDX_W'((k < SWEEP_LEN) ? k : SWEEP_LEN - 1)) begin
            n_fail++;
            $display("FAIL %s_busy k=%0d: busy=%b vec_idx=%0d", tag, k, busy, vec_idx);
         end
         if (k >= 1) begin
            v  = 3'((k - 1) % 8);
            em = (int'(v[0]) + int'(v[1]) + int'(v[2])) >= 2;
            ex = (v[0] == v[1]);
            n_checks++;
            if ({maj_o, xnor_o, xnor_alt_o, maj_alt_o, mismatch} !== {em, ex, ex, em ^ fi, fi}) begin
               n_fail++;
               $display("FAIL %s_vec v=%b: maj,xnor,xnor_alt,maj_alt,mism=%b want %b", tag, v,
                        {maj_o, xnor_o, xnor_alt_o, maj_alt_o, mismatch},
                        {em, ex, ex, em ^ fi, fi});
            end
         end
         step();
      end
      n_checks++;
      if ({busy, done, pass} !== {1'b0, 1'b1, ~fi}) begin
         n_fail++;
         $display("FAIL %s_done: busy/done/pass=%b want %b", tag, {busy, done, pass}, {2'b01, ~fi});
      end
   endtask

   task automatic test_sweep();
      run_sweep(1'b0, "sweep");
   endtask

   task automatic test_fault_sweep();
      run_sweep(1'b1, "fault");
      fault_inj = 1'b0;
      mode = 1'b0;
      step();
      n_checks++;
      if ({busy, done, pass} !== 3'b000) begin
         n_fail++;
         $display("FAIL done_to_idle: busy/done/pass=%b want 000", {busy, done, pass});
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: done=%b pass=%b after %0d cycles, want 1/1", tag, done, pass, n);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n = 0;
      launch(1'b0);
      while (vec_idx !== IDX_W'(5) && n < 40) begin
         step();
         n++;
      end
      n_checks++;
      if (vec_idx !== IDX_W'(5)) begin
         n_fail++;
         $display("FAIL midrst_reach: vec_idx=%0d want 5", vec_idx);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, pass, mismatch} !== 4'b0000 || vec_idx !== '0) begin
         n_fail++;
         $display("FAIL midrst_clear: busy/done/pass/mism=%b vec_idx=%0d want 0000/0",
                  {busy, done, pass, mismatch}, vec_idx);
      end
      step();
      rst_n = 1'b1;
      step();
      launch(1'b0);
      wait_done("midrst_rerun");
   endtask

   task automatic test_ignored_start();
      mode = 1'b0;
      step();
      launch(1'b0);
      step(); step(); step();
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++;
      if (vec_idx !== IDX_W'(4) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_in_sweep: vec_idx=%0d busy=%b want 4/1", vec_idx, busy);
      end
      mode = 1'b0;
      step();
      n_checks++;
      if (vec_idx !== IDX_W'(5) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_drop_in_sweep: vec_idx=%0d busy=%b want 5/1", vec_idx, busy);
      end
      mode = 1'b1;
      wait_done("sweep_after_ignored_start");
      mode = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL start_mode0: busy/done=%b want 00", {busy, done});
      end
   endtask

   initial begin
      {mode, start, a_i, b_i, c_i, fault_inj} = '0;
      rst_n = 1'b0;
      test_reset();
      test_external();
      test_sweep();
      test_fault_sweep();
      test_reset_mid_sweep();
      test_ignored_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
